// File: rtl/axi_hs_fifo_if.sv
// rtl/axi_hs_fifo_if.sv - handshake/status bundle for axi_hs_fifo
interface axi_hs_fifo_if #(
    parameter int DW = 8,
    parameter int CW = 3
);
    logic          i_flush;
    logic          i_valid;
    logic [DW-1:0] i_data;
    logic          o_ready;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic          i_ready;
    logic [CW-1:0] o_count;
    logic          o_full;
    logic          o_empty;
    logic          o_afull;
    logic          o_aempty;

    // Producer/consumer side (drives requests, observes status)
    modport master (
        output i_flush, i_valid, i_data, i_ready,
        input  o_ready, o_valid, o_data, o_count,
        input  o_full, o_empty, o_afull, o_aempty
    );

    // FIFO side
    modport slave (
        input  i_flush, i_valid, i_data, i_ready,
        output o_ready, o_valid, o_data, o_count,
        output o_full, o_empty, o_afull, o_aempty
    );
endinterface

// File: rtl/axi_hs_fifo.sv
// rtl/axi_hs_fifo.sv - first-word fall-through handshake FIFO with optional output register
module axi_hs_fifo #(
    parameter int DW      = 8,
    parameter int DP      = 4,
    parameter int OUT_REG = 0,
    parameter int AF_LVL  = DP - 1,
    parameter int AE_LVL  = 1,
    localparam int CAP    = DP + OUT_REG,
    localparam int CW     = $clog2(CAP + 1)
) (
    input  logic         i_clk,
    input  logic         i_resetn,
    axi_hs_fifo_if.slave bus
);
    localparam int PW = $clog2(DP);

    logic [DW-1:0] mem [DP];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic          arr_wr;
    logic          arr_rd;
    logic [DW-1:0] arr_head;

    // Pointers wrap explicitly at DP-1 so non-power-of-2 depths work
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DP - 1)) ? '0 : p + PW'(1);
    endfunction

    assign arr_head     = mem[rptr];
    assign bus.o_ready  = (count < CW'(CAP));
    assign push         = bus.i_valid & bus.o_ready;
    assign pop          = bus.o_valid & bus.i_ready;
    assign bus.o_count  = count;
    assign bus.o_full   = (count == CW'(CAP));
    assign bus.o_empty  = (count == '0);
    assign bus.o_afull  = (int'(count) >= AF_LVL);
    assign bus.o_aempty = (int'(count) <= AE_LVL);

    generate
        if (OUT_REG == 0) begin : g_direct
            assign arr_wr      = push;
            assign arr_rd      = pop;
            assign bus.o_valid = (count != '0);
            assign bus.o_data  = arr_head;
        end else begin : g_oreg
            logic          ov;
            logic [DW-1:0] od;
            logic          load;
            logic          arr_empty;

            // The output register counts as one stored entry, so the array is empty when count == ov
            assign arr_empty = (count == CW'(ov));
            assign load      = ~ov | pop;
            assign arr_rd    = load & ~arr_empty;
            assign arr_wr    = push & ~(load & arr_empty);

            // Output register: refill from array head, else bypass the incoming word, else go empty
            always_ff @(posedge i_clk or negedge i_resetn) begin
                if (!i_resetn) begin
                    ov <= 1'b0;
                    od <= '0;
                end else if (bus.i_flush) begin
                    ov <= 1'b0;
                end else if (load) begin
                    if (!arr_empty) begin
                        ov <= 1'b1;
                        od <= arr_head;
                    end else if (push) begin
                        ov <= 1'b1;
                        od <= bus.i_data;
                    end else begin
                        ov <= 1'b0;
                    end
                end
            end

            assign bus.o_valid = ov;
            assign bus.o_data  = od;
        end
    endgenerate

    // Storage array write; cleared on reset so o_data reads zero
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            for (int i = 0; i < DP; i++) begin
                mem[i] <= '0;
            end
        end else if (!bus.i_flush && arr_wr) begin
            mem[wptr] <= bus.i_data;
        end
    end

    // Pointer and occupancy bookkeeping; flush overrides any same-cycle push/pop
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (bus.i_flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (arr_wr) begin
                wptr <= ptr_inc(wptr);
            end
            if (arr_rd) begin
                rptr <= ptr_inc(rptr);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_axi_hs_fifo.sv
// tb/tb_axi_hs_fifo.sv - scoreboard bench for axi_hs_fifo over four depth/output-register configurations
module tb_axi_hs_fifo;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       flush = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] data = 8'h00;
    logic       ready = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s dut%0d t=%0t actual=%0h required=%0h", nm, g, $time, act, req);
        end
    endtask

    // Configurations: 0 DP4/direct, 1 DP4/outreg, 2 DP3/direct, 3 DP3/outreg
    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int L_DP  = (g < 2) ? 4 : 3;
        localparam int L_OR  = g % 2;
        localparam int L_CAP = L_DP + L_OR;
        localparam int L_CW  = $clog2(L_CAP + 1);

        axi_hs_fifo_if #(.DW(8), .CW(L_CW)) bus ();

        assign bus.i_flush = flush;
        assign bus.i_valid = valid;
        assign bus.i_data  = data;
        assign bus.i_ready = ready;

        axi_hs_fifo #(.DW(8), .DP(L_DP), .OUT_REG(L_OR)) dut (
            .i_clk    (clk),
            .i_resetn (resetn),
            .bus      (bus.slave)
        );

        logic [7:0] exp_q [$];

        // Reference model: expected words enter the queue when a push is accepted
        always @(posedge clk or negedge resetn) begin
            if (!resetn || flush) begin
                exp_q.delete();
            end else begin
                automatic int  n     = exp_q.size();
                automatic bit  p_in  = valid && (n < L_CAP);
                automatic bit  p_out = ready && (n != 0);
                if (p_out) begin
                    void'(exp_q.pop_front());
                end
                if (p_in) begin
                    exp_q.push_back(data);
                end
            end
        end

        // Monitor: compare presented head and status against the scoreboard
        always @(negedge clk) begin
            automatic int n = exp_q.size();
            chk("count",  g, 32'(bus.o_count), 32'(n));
            chk("valid",  g, 32'(bus.o_valid), 32'(n != 0));
            chk("ready",  g, 32'(bus.o_ready), 32'(n < L_CAP));
            chk("full",   g, 32'(bus.o_full),  32'(n == L_CAP));
            chk("empty",  g, 32'(bus.o_empty), 32'(n == 0));
            chk("afull",  g, 32'(bus.o_afull), 32'(n >= L_DP - 1));
            chk("aempty", g, 32'(bus.o_aempty), 32'(n <= 1));
            if (n != 0) begin
                chk("data", g, 32'(bus.o_data), 32'(exp_q[0]));
            end else if (!resetn) begin
                chk("rst_data", g, 32'(bus.o_data), 32'h0);
            end
        end
    end

    task automatic cyc(input logic v, input logic [7:0] d, input logic r, input logic f);
        valid = v;
        data  = d;
        ready = r;
        flush = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;

        // Single push into empty FIFO, consumer stalled
        cyc(1'b1, 8'h11, 1'b0, 1'b0);
        // Fill past every capacity; extra words must be refused
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b1, 8'(i), 1'b0, 1'b0);
        end
        // Full with push and pop requested: pop only, 0xEE not taken
        cyc(1'b1, 8'hEE, 1'b1, 1'b0);
        // Drain to empty
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end

        // Prime two entries, then steady push&pop across several pointer wraps
        cyc(1'b1, 8'h20, 1'b0, 1'b0);
        cyc(1'b1, 8'h21, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 8'(8'h22 + i), 1'b1, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end

        // Three entries then flush with a simultaneous push of 0xAA and pop
        cyc(1'b1, 8'h31, 1'b0, 1'b0);
        cyc(1'b1, 8'h32, 1'b0, 1'b0);
        cyc(1'b1, 8'h33, 1'b0, 1'b0);
        cyc(1'b1, 8'hAA, 1'b1, 1'b1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b1, 8'h55, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);

        // Mixed irregular traffic
        for (int i = 0; i < 20; i++) begin
            cyc((i % 3) != 2, 8'(8'h80 + i), (i % 4) >= 2, 1'b0);
        end
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end

        // Three entries, then asynchronous reset between edges
        cyc(1'b1, 8'h41, 1'b0, 1'b0);
        cyc(1'b1, 8'h42, 1'b0, 1'b0);
        cyc(1'b1, 8'h43, 1'b0, 1'b0);
        valid = 1'b0;
        #2;
        resetn = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        cyc(1'b1, 8'h77, 1'b0, 1'b0);
        cyc(1'b1, 8'h78, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
